// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller.
// State encoding, IO address tag and load/store length codes.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_LS_RD,
    S_LS_WR,
    S_DONE
  } state_e;

  localparam logic [1:0] IO_MASK_DEF = 2'b11;

  localparam logic [2:0] LEN_B = 3'b001;
  localparam logic [2:0] LEN_H = 3'b010;
  localparam logic [2:0] LEN_W = 3'b100;

  // Index of the final byte for a given length code.
  function automatic logic [1:0] last_idx(
    input logic [2:0] l
  );
    logic [1:0] r;
    r = 2'd0;
    case (l)
      LEN_H:   r = 2'd1;
      LEN_W:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter for instruction fetch and load/store.
// Ports: clk/rst/rdy, RAM side mem_din/mem_dout/mem_a/mem_wr,
// io_buffer_full, ifetch if_req/if_addr/if_done/if_data,
// load/store ls_sig/load_or_store/len/ls_addr/store_val/
// ls_done/ls_data, and clear (pipeline flush).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_MASK = IO_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_sig,
  input  logic        load_or_store,
  input  logic [2:0]  len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] store_val,
  output logic        ls_done,
  output logic [31:0] ls_data,
  input  logic        clear
);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic [1:0]  base_q;
  logic        inflt_q;
  logic        io_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_data_q;
  logic        if_done_q;
  logic        ls_done_q;

  logic [31:0] word_d;
  logic [1:0]  nxt_d;
  logic [1:0]  off_d;
  logic        more_d;
  logic        stall_d;

  always_comb begin
    word_d = data_q;
    word_d[{cnt_q, 3'b000} +: 8] = mem_din;
    nxt_d = cnt_q + 2'd1;
    // offset of the address currently on the bus
    off_d = mem_a_q[1:0] - base_q;
    more_d = (off_d != last_q);
    stall_d = io_q && io_buffer_full;
  end

  assign mem_wr   = rdy && (state_q == S_LS_WR) && !stall_d;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_data  = ls_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      base_q     <= 2'd0;
      inflt_q    <= 1'b0;
      io_q       <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!clear && ls_sig) begin
            base_q     <= ls_addr[1:0];
            mem_a_q    <= ls_addr;
            last_q     <= last_idx(len);
            cnt_q      <= 2'd0;
            inflt_q    <= 1'b0;
            data_q     <= '0;
            wdata_q    <= store_val;
            mem_dout_q <= store_val[7:0];
            io_q       <= (ls_addr[17:16] == IO_MASK);
            state_q    <= load_or_store ? S_LS_WR : S_LS_RD;
          end else if (!clear && if_req) begin
            base_q  <= if_addr[1:0];
            mem_a_q <= if_addr;
            last_q  <= 2'd3;
            cnt_q   <= 2'd0;
            inflt_q <= 1'b0;
            data_q  <= '0;
            io_q    <= 1'b0;
            state_q <= S_IF_RD;
          end
        end
        S_IF_RD, S_LS_RD: begin
          if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            inflt_q <= 1'b0;
          end else begin
            if (more_d) mem_a_q <= mem_a_q + 32'd1;
            // first cycle only issues; data trails by one
            inflt_q <= 1'b1;
            if (inflt_q) begin
              data_q <= word_d;
              cnt_q  <= nxt_d;
              if (cnt_q == last_q) begin
                state_q <= S_DONE;
                cnt_q   <= 2'd0;
                inflt_q <= 1'b0;
                if (state_q == S_IF_RD) begin
                  if_data_q <= word_d;
                  if_done_q <= 1'b1;
                end else begin
                  ls_data_q <= word_d;
                  ls_done_q <= 1'b1;
                end
              end
            end
          end
        end
        S_LS_WR: begin
          if (!stall_d) begin
            if (cnt_q == last_q) begin
              state_q   <= S_DONE;
              cnt_q     <= 2'd0;
              ls_done_q <= 1'b1;
            end else begin
              cnt_q      <= nxt_d;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= wdata_q[{nxt_d, 3'b000} +: 8];
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
